inta_sequencer: RTL and testbench
=================================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 The module SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Parameter: PULSE_CYCLES, 4, clock cycles each INTA pulse is held low (legal range 2..15).
REQ-003 Parameter: GAP_CYCLES, 3, clock cycles INTA is held high between pulses and after the final pulse (legal range 1..15).
REQ-004 Port: clock  in  1  system clock; all state updates on the rising edge.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: interrupt_request  in  1  INT from the interrupt controller; asynchronous; active high.
REQ-007 Port: interrupt_enable  in  1  CPU interrupt-enable flag; a sequence starts only while this is 1.
REQ-008 Port: mode_8086  in  1  1 = 8086 two-pulse mode; 0 = 8080/85 three-pulse CALL mode.
REQ-009 Port: data_bus_in  in  8  byte driven by the controller while interrupt_acknowledge_n is low.
REQ-010 Port: interrupt_acknowledge_n  out  1  INTA strobe to the controller; active low.
REQ-011 Port: vector_out  out  8  captured 8086 vector type.
REQ-012 Port: call_address  out  16  captured 8080 CALL target, {high byte, low byte}.
REQ-013 Port: vector_valid  out  1  one-cycle pulse marking vector_out/call_address as updated.
REQ-014 Port: opcode_error  out  1  one-cycle pulse: the 8080 first byte was not 8'hCD.
REQ-015 Port: busy  out  1  high from sequence start until return to IDLE.

Function
REQ-016 interrupt_request SHALL pass through a two-flop synchronizer; the FSM sees only the synchronized value.
REQ-017 The FSM states SHALL be IDLE, PULSE_LOW, PULSE_GAP and DONE, with a 2-bit pulse index (1..3) and a 4-bit cycle counter.
REQ-018 IDLE->PULSE_LOW SHALL occur when synchronized INT=1 and interrupt_enable=1; the index is set to 1, mode_8086 is latched for the whole sequence, and interrupt_acknowledge_n falls on the same edge.
REQ-019 In PULSE_LOW, interrupt_acknowledge_n SHALL stay 0 for exactly PULSE_CYCLES cycles; data_bus_in is sampled on the last low cycle only.
REQ-020 PULSE_LOW->PULSE_GAP SHALL follow that last cycle; interrupt_acknowledge_n stays 1 for exactly GAP_CYCLES cycles.
REQ-021 PULSE_GAP->PULSE_LOW with index+1 SHALL occur if the index is below the pulse count (2 in 8086 mode, 3 in 8080 mode); otherwise the FSM goes to DONE.
REQ-022 In 8086 mode, the pulse-1 byte SHALL be ignored and the pulse-2 byte loaded into vector_out.
REQ-023 In 8080 mode, the pulse-1 byte SHALL be checked against 8'hCD, pulse 2 loaded into call_address[7:0], and pulse 3 into call_address[15:8].
REQ-024 In DONE (one cycle), the FSM SHALL pulse vector_valid, update outputs atomically (no partial update visible earlier), and return to IDLE.
REQ-025 On an 8080 opcode mismatch, the sequence SHALL still complete all three pulses; opcode_error pulses in DONE, vector_valid stays 0, and call_address holds its old value.
REQ-026 interrupt_enable deasserting or INT dropping mid-sequence SHALL NOT abort the sequence; INTA pulse count and timing are unchanged.
REQ-027 A new sequence SHALL NOT start on the cycle DONE returns to IDLE; re-arm requires synchronized INT=1 in IDLE on a later cycle.
REQ-028 A mode_8086 change mid-sequence SHALL be ignored until the next IDLE exit.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 While reset_n=0, interrupt_acknowledge_n=1, vector_out=0, call_address=0, vector_valid=0, opcode_error=0, busy=0, state=IDLE, counters=0 and synchronizer flops=0.
REQ-031 Reset asserted mid-pulse SHALL raise interrupt_acknowledge_n immediately (asynchronously) and discard partial bytes.
REQ-032 After reset release, the earliest sequence start SHALL be the third rising edge, due to synchronizer latency.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the CALL opcode constant 8'hCD, and pulse counts 2 and 3.
REQ-034 The INT synchronizer SHALL be a separate sub-module, inta_request_sync.

Verification
REQ-035 8086, PULSE=4/GAP=3, INT high, bus=8'h0A on pulse 2 -> two 4-cycle low pulses 3 cycles apart, vector_out=8'h0A, one vector_valid.
REQ-036 8080, bus bytes CD/40/12 -> three pulses, call_address=16'h1240, vector_valid=1 once, opcode_error=0.
REQ-037 8080, first byte 8'hC3 -> three pulses, opcode_error pulse, call_address unchanged, no vector_valid.
REQ-038 INT high with interrupt_enable=0 -> no INTA; then set enable=1 -> sequence starts next cycle.
REQ-039 reset_n low during pulse 2 -> interrupt_acknowledge_n=1 at once, outputs zero, no vector_valid after release.
REQ-040 INT held high continuously -> back-to-back sequences separated by at least one IDLE cycle.

Source files
------------

// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the INTA sequencer: FSM states, the 8080 CALL
// opcode and the pulse counts of the two acknowledge protocols.
package inta_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_LOW = 2'd1,
    PULSE_GAP = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [1:0] PULSES_8086 = 2'd2;
  localparam logic [1:0] PULSES_8080 = 2'd3;

  function automatic logic [1:0] pulse_count(input logic is_8086);
    return is_8086 ? PULSES_8086 : PULSES_8080;
  endfunction

endpackage

// File: rtl/inta_request_sync.sv
// Two-flop synchronizer bringing the asynchronous INT request into the
// clock domain of the sequencer.
module inta_request_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// Generates the INTA strobe train for 8086 (two pulses) or 8080/85 (three
// pulses, CALL opcode + address) and captures the bytes the controller returns.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_request,
  input  logic        interrupt_enable,
  input  logic        mode_8086,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic [7:0]  vector_out,
  output logic [15:0] call_address,
  output logic        vector_valid,
  output logic        opcode_error,
  output logic        busy
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        err_q, err_d;
  logic [7:0]  b2_q, b2_d;
  logic [7:0]  b3_q, b3_d;
  logic [7:0]  vec_q, vec_d;
  logic [15:0] call_q, call_d;
  logic        int_sync;

  inta_request_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (interrupt_request),
    .sync_o  (int_sync)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      b2_q    <= '0;
      b3_q    <= '0;
      vec_q   <= '0;
      call_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      vec_q   <= vec_d;
      call_q  <= call_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    vec_d   = vec_q;
    call_d  = call_q;
    case (state_q)
      IDLE: begin
        if (int_sync && interrupt_enable) begin
          state_d = PULSE_LOW;
          idx_d   = 2'd1;
          cnt_d   = '0;
          mode_d  = mode_8086;
          err_d   = 1'b0;
        end
      end
      PULSE_LOW: begin
        // Bus bytes are only trusted on the final low cycle of each pulse.
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = PULSE_GAP;
          case (idx_q)
            2'd1:    err_d = !mode_q && (data_bus_in != CALL_OPCODE);
            2'd2:    b2_d  = data_bus_in;
            default: b3_d  = data_bus_in;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      PULSE_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q < pulse_count(mode_q)) begin
            state_d = PULSE_LOW;
            idx_d   = idx_q + 2'd1;
          end else begin
            // Outputs change together on entry to DONE, alongside the strobe.
            state_d = DONE;
            if (mode_q) begin
              vec_d = b2_q;
            end else if (!err_q) begin
              call_d = {b3_q, b2_q};
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign interrupt_acknowledge_n = (state_q != PULSE_LOW);
  assign busy                    = (state_q != IDLE);
  assign vector_valid            = (state_q == DONE) && (mode_q || !err_q);
  assign opcode_error            = (state_q == DONE) && !mode_q && err_q;
  assign vector_out              = vec_q;
  assign call_address            = call_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: table of acknowledge sequences plus hand-written
// enable, reset and back-to-back cases; completions checked from a queue.
module tb_inta_sequencer;

  localparam int PULSE = 4;
  localparam int GAP   = 3;

  logic        clock;
  logic        reset_n;
  logic        interrupt_request;
  logic        interrupt_enable;
  logic        mode_8086;
  logic [7:0]  data_bus_in;
  logic        interrupt_acknowledge_n;
  logic [7:0]  vector_out;
  logic [15:0] call_address;
  logic        vector_valid;
  logic        opcode_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic        e;
    logic [7:0]  vec;
    logic [15:0] call;
  } exp_t;

  typedef struct {
    logic        m;
    logic        flip;
    logic        drop_en;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic        ev;
    logic        ee;
    logic [7:0]  evec;
    logic [15:0] ecall;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[8];

  inta_sequencer #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .interrupt_request       (interrupt_request),
    .interrupt_enable        (interrupt_enable),
    .mode_8086               (mode_8086),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .vector_out              (vector_out),
    .call_address            (call_address),
    .vector_valid            (vector_valid),
    .opcode_error            (opcode_error),
    .busy                    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (vector_valid || opcode_error) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done_flags", {30'd0, vector_valid, opcode_error}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("vector_valid", vector_valid, e.v);
        chk("opcode_error", opcode_error, e.e);
        chk("vector_out", vector_out, e.vec);
        chk("call_address", call_address, e.call);
      end
    end
  end

  task automatic run_seq(input vec_t v);
    int np, wt, lw, gw, lows, done_at;
    logic [7:0] bytes [3];
    bytes[0] = v.b1;
    bytes[1] = v.b2;
    bytes[2] = v.b3;
    np = v.m ? 2 : 3;
    exp_q.push_back('{v.ev, v.ee, v.evec, v.ecall});
    mode_8086         = v.m;
    interrupt_enable  = 1'b1;
    interrupt_request = 1'b1;
    for (int p = 0; p < np; p++) begin
      wt = 0;
      while (interrupt_acknowledge_n && wt < 50) begin
        @(negedge clock);
        wt++;
      end
      if (interrupt_acknowledge_n) begin
        chk("pulse_start_timeout", interrupt_acknowledge_n, 1'b0);
        return;
      end
      data_bus_in = bytes[p];
      if (p == 0) begin
        interrupt_request = 1'b0;
        if (v.drop_en) interrupt_enable = 1'b0;
        if (v.flip) mode_8086 = ~v.m;
        chk("busy_in_pulse", busy, 1'b1);
      end
      lw = 0;
      while (!interrupt_acknowledge_n && lw < 40) begin
        lw++;
        @(negedge clock);
      end
      chk("pulse_low_width", lw, PULSE);
      if (p < np - 1) begin
        gw = 0;
        while (interrupt_acknowledge_n && gw < 40) begin
          gw++;
          @(negedge clock);
        end
        chk("pulse_gap_width", gw, GAP);
      end
    end
    lows    = 0;
    done_at = 0;
    for (int i = 1; i <= GAP + 8; i++) begin
      @(negedge clock);
      if (!interrupt_acknowledge_n) lows++;
      if ((vector_valid || opcode_error) && done_at == 0) done_at = i;
    end
    chk("extra_pulses", lows, 0);
    chk("done_latency", done_at, GAP);
    chk("idle_after_seq", busy, 1'b0);
    chk("vector_out_hold", vector_out, v.evec);
    chk("call_address_hold", call_address, v.ecall);
    mode_8086        = v.m;
    interrupt_enable = 1'b1;
  endtask

  initial begin
    int wt, lows;
    // m flip drop  b1     b2     b3     ev    ee    evec   ecall
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h0A, 8'h00, 1'b1, 1'b0, 8'h0A, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 8'hCD, 8'h40, 8'h12, 1'b1, 1'b0, 8'h0A, 16'h1240};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'hC3, 8'h55, 8'h66, 1'b0, 1'b1, 8'h0A, 16'h1240};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'hCD, 8'hF3, 8'h00, 1'b1, 1'b0, 8'hF3, 16'h1240};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'hCD, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hF3, 16'hFF00};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'hCD, 8'h34, 8'h12, 1'b1, 1'b0, 8'hF3, 16'h1234};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h11, 8'h5C, 8'h00, 1'b1, 1'b0, 8'h5C, 16'h1234};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h02, 1'b0, 1'b1, 8'h5C, 16'h1234};

    reset_n           = 1'b0;
    interrupt_request = 1'b0;
    interrupt_enable  = 1'b0;
    mode_8086         = 1'b0;
    data_bus_in       = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_inta_n", interrupt_acknowledge_n, 1'b1);
    chk("rst_vector_out", vector_out, 8'h00);
    chk("rst_call_address", call_address, 16'h0000);
    chk("rst_vector_valid", vector_valid, 1'b0);
    chk("rst_opcode_error", opcode_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) run_seq(tbl[i]);

    // Enable gating: INT held high while disabled must not start anything.
    mode_8086         = 1'b1;
    data_bus_in       = 8'h77;
    interrupt_enable  = 1'b0;
    interrupt_request = 1'b1;
    lows = 0;
    repeat (10) begin
      @(negedge clock);
      if (!interrupt_acknowledge_n) lows++;
    end
    chk("no_inta_when_disabled", lows, 0);
    chk("idle_when_disabled", busy, 1'b0);
    exp_q.push_back('{1'b1, 1'b0, 8'h77, 16'h1234});
    interrupt_enable = 1'b1;
    @(negedge clock);
    chk("start_after_enable", interrupt_acknowledge_n, 1'b0);
    interrupt_request = 1'b0;
    repeat (2 * (PULSE + GAP) + 6) @(negedge clock);
    chk("enable_seq_idle", busy, 1'b0);
    chk("enable_seq_vector", vector_out, 8'h77);

    // Reset in the middle of pulse 2 of an 8080 sequence.
    mode_8086         = 1'b0;
    data_bus_in       = 8'hCD;
    interrupt_request = 1'b1;
    wt = 0;
    while (interrupt_acknowledge_n && wt < 50) begin @(negedge clock); wt++; end
    interrupt_request = 1'b0;
    wt = 0;
    while (!interrupt_acknowledge_n && wt < 50) begin @(negedge clock); wt++; end
    wt = 0;
    while (interrupt_acknowledge_n && wt < 50) begin @(negedge clock); wt++; end
    chk("pulse2_reached", interrupt_acknowledge_n, 1'b0);
    data_bus_in = 8'h99;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_inta_n", interrupt_acknowledge_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_vector_out", vector_out, 8'h00);
    chk("midrst_call_address", call_address, 16'h0000);
    chk("midrst_vector_valid", vector_valid, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    chk("postrst_inta_n", interrupt_acknowledge_n, 1'b1);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_call_address", call_address, 16'h0000);

    // Earliest start after reset release is the third rising edge.
    reset_n           = 1'b0;
    mode_8086         = 1'b1;
    data_bus_in       = 8'h21;
    interrupt_enable  = 1'b1;
    interrupt_request = 1'b1;
    exp_q.push_back('{1'b1, 1'b0, 8'h21, 16'h0000});
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("relstart_edge1", interrupt_acknowledge_n, 1'b1);
    @(negedge clock);
    chk("relstart_edge2", interrupt_acknowledge_n, 1'b1);
    @(negedge clock);
    chk("relstart_edge3", interrupt_acknowledge_n, 1'b0);
    interrupt_request = 1'b0;
    repeat (2 * (PULSE + GAP) + 6) @(negedge clock);
    chk("relstart_vector", vector_out, 8'h21);

    // INT held high: back-to-back sequences with one IDLE cycle between.
    data_bus_in = 8'h3C;
    exp_q.push_back('{1'b1, 1'b0, 8'h3C, 16'h0000});
    exp_q.push_back('{1'b1, 1'b0, 8'h3C, 16'h0000});
    interrupt_request = 1'b1;
    wt = 0;
    while (!vector_valid && wt < 60) begin @(negedge clock); wt++; end
    chk("b2b_first_done", vector_valid, 1'b1);
    @(negedge clock);
    chk("b2b_idle_gap", busy, 1'b0);
    @(negedge clock);
    chk("b2b_restart", interrupt_acknowledge_n, 1'b0);
    interrupt_request = 1'b0;
    repeat (30) @(negedge clock);
    chk("b2b_idle_end", busy, 1'b0);
    chk("b2b_vector", vector_out, 8'h3C);

    chk("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
